// File: rtl/serial_adder_ctrl.sv
// ============================================================================
//  Module      : serial_adder_ctrl (with helper half_adder_dataflow)
//  Description : Bit-serial WIDTH-bit adder with a start/ready/busy/done
//                handshake. A single full-adder cell is reused once per bit.
//                The cell is built from two half adders and an OR gate. The
//                carry is held in a flop between bits.
//  Ports       : clk       - system clock, rising-edge active
//                rst_n     - asynchronous active-low reset
//                start     - request, accepted on an edge where ready=1
//                a, b      - operands, sampled on the accepting edge only
//                sub       - (SERIAL_ADDER_SUB_EN only) 1 = compute a-b
//                ready     - block can accept start (IDLE or DONE)
//                busy      - serial operation in progress (RUN)
//                done      - one-cycle pulse, result valid
//                sum       - result, held until the next result lands
//                carry_out - final MSB carry (no-borrow flag when subtracting)
//  Options     : define SERIAL_ADDER_SUB_EN to add the sub port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_adder_dataflow (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Single full-adder cell: two half adders, OR merges their carries.
    logic w_s0, w_c0, w_bit, w_c1, w_cout;

    half_adder_dataflow u_ha0 (.x(a_sh_q[0]), .y(b_sh_q[0]), .s(w_s0),  .c(w_c0));
    half_adder_dataflow u_ha1 (.x(w_s0),      .y(c_q),       .s(w_bit), .c(w_c1));
    assign w_cout = w_c0 | w_c1;

    // Operand B load value and carry seed. Subtraction is a + ~b + 1.
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_init;
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_init = sub;
`else
    assign w_b_load = b;
    assign w_c_init = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        carry_d = carry_q;
        done_d  = 1'b0;

        case (state_q)
            // DONE accepts a new request exactly like IDLE (back-to-back).
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = w_b_load;
                    c_d     = w_c_init;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_d    = w_cout;
                // Result assembled LSB-first by shifting in from the top.
                res_d  = {w_bit, res_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST_BIT) begin
                    // Visible result only moves here, so the previous
                    // answer stays readable for the whole RUN phase.
                    sum_d   = {w_bit, res_q[WIDTH-1:1]};
                    carry_d = w_cout;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake outputs are registered copies decoded from next state.
        ready_d = (state_d != S_RUN);
        busy_d  = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Self-checking bench for serial_adder_ctrl (WIDTH=8).
//                Expected results come from plain integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Results of the most recent run_op call.
    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    int               r_cyc;
    bit               r_seen;
    bit               r_busy_bad;
    bit               r_sum_moved;

    // Reference: {carry_out, sum} from plain arithmetic.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input bit s);
        logic [WIDTH-1:0] diff;
        if (s) begin
            diff = x - y;
            return {(x >= y), diff};
        end
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Drives one request starting at the current (negedge) time, then waits
    // for done. With noise=1, start stays high with random operands while
    // the operation runs. Returns at the negedge where done is seen.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input bit isub, input bit noise);
        logic [WIDTH-1:0] held;
        held  = sum;
        start = 1'b1;
        a     = ia;
        b     = ib;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = isub;
`endif
        r_cyc = 0; r_seen = 0; r_busy_bad = 0; r_sum_moved = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            r_cyc++;
            start = noise && (r_cyc < WIDTH);
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub   = 1'($urandom);
`endif
            if (done === 1'b1) begin
                r_seen = 1;
                break;
            end
            if (busy !== 1'b1 || ready !== 1'b0) r_busy_bad = 1;
            if (sum !== held) r_sum_moved = 1;
        end
        r_sum = sum;
        r_co  = carry_out;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            n_tests++;
            if ({ready, busy, done, carry_out, sum} !== {4'b1000, 8'h00}) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got rdy=%b bsy=%b dn=%b co=%b sum=%h, expected 1 0 0 0 00",
                         i, ready, busy, done, carry_out, sum);
            end
        end
    endtask

    task automatic test_basic;
        logic [WIDTH:0] exp;
        exp = model(8'h5A, 8'h3C, 0);
        run_op(8'h5A, 8'h3C, 0, 0);
        n_tests++;
        if ({r_co, r_sum} !== exp) begin
            n_fail++;
            $display("FAIL add_5a_3c: got %h, expected %h", {r_co, r_sum}, exp);
        end
        n_tests++;
        if (!r_seen || r_cyc != WIDTH + 1 || r_busy_bad || r_sum_moved) begin
            n_fail++;
            $display("FAIL add_5a_3c_timing: seen=%0d cyc=%0d busy_bad=%0d sum_moved=%0d, expected 1 %0d 0 0",
                     r_seen, r_cyc, r_busy_bad, r_sum_moved, WIDTH + 1);
        end
        @(negedge clk);
        n_tests++;
        if ({done, ready, busy, sum} !== {3'b010, 8'h96}) begin
            n_fail++;
            $display("FAIL add_5a_3c_hold: got dn=%b rdy=%b bsy=%b sum=%h, expected 0 1 0 96",
                     done, ready, busy, sum);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        run_op(8'hFF, 8'h01, 0, 0);
        n_tests++;
        if ({r_co, r_sum} !== 9'h100) begin
            n_fail++;
            $display("FAIL add_ff_01: got %h, expected 100", {r_co, r_sum});
        end
        // Issue the next request in the DONE cycle.
        run_op(8'h80, 8'h80, 0, 0);
        n_tests++;
        if ({r_co, r_sum} !== 9'h100 || !r_seen || r_cyc != WIDTH + 1 || r_busy_bad) begin
            n_fail++;
            $display("FAIL b2b_80_80: got %h cyc=%0d busy_bad=%0d, expected 100 cyc=%0d busy_bad=0",
                     {r_co, r_sum}, r_cyc, r_busy_bad, WIDTH + 1);
        end
    endtask

    task automatic test_start_during_run;
        int extra;
        @(negedge clk);
        run_op(8'h01, 8'h02, 0, 1);
        n_tests++;
        if ({r_co, r_sum} !== 9'h003 || r_cyc != WIDTH + 1 || r_busy_bad) begin
            n_fail++;
            $display("FAIL start_in_run: got %h cyc=%0d busy_bad=%0d, expected 003 cyc=%0d busy_bad=0",
                     {r_co, r_sum}, r_cyc, r_busy_bad, WIDTH + 1);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL start_in_run_single_done: got %0d extra active cycles, expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_run;
        int dones;
        @(negedge clk);
        start = 1'b1; a = 8'hF0; b = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ready, busy, done, carry_out, sum} !== {4'b1000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid_run: got rdy=%b bsy=%b dn=%b co=%b sum=%h, expected 1 0 0 0 00",
                     ready, busy, done, carry_out, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || ready !== 1'b1) dones++;
        end
        n_tests++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_mid_run_quiet: got %0d bad cycles, expected 0", dones);
        end
        run_op(8'h0F, 8'h01, 0, 0);
        n_tests++;
        if ({r_co, r_sum} !== 9'h010 || r_cyc != WIDTH + 1) begin
            n_fail++;
            $display("FAIL after_reset_0f_01: got %h cyc=%0d, expected 010 cyc=%0d",
                     {r_co, r_sum}, r_cyc, WIDTH + 1);
        end
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] ra, rb;
        logic [WIDTH:0]   exp;
        bit               rs, noise;
        for (int i = 0; i < 24; i++) begin
            ra    = WIDTH'($urandom);
            rb    = WIDTH'($urandom);
            noise = 1'($urandom);
            rs    = 0;
`ifdef SERIAL_ADDER_SUB_EN
            rs    = 1'($urandom);
`endif
            if (i % 6 == 1) ra = '1;
            if (i % 6 == 2) rb = '0;
            // Two times in three, wait a cycle; otherwise go back-to-back.
            if ($urandom_range(2) != 0) @(negedge clk);
            exp = model(ra, rb, rs);
            run_op(ra, rb, rs, noise);
            n_tests++;
            if ({r_co, r_sum} !== exp || r_cyc != WIDTH + 1 || r_busy_bad || r_sum_moved) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h sub=%0d: got %h cyc=%0d busy_bad=%0d moved=%0d, expected %h cyc=%0d",
                         i, ra, rb, rs, {r_co, r_sum}, r_cyc, r_busy_bad, r_sum_moved, exp, WIDTH + 1);
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        @(negedge clk);
        run_op(8'h10, 8'h01, 1, 0);
        n_tests++;
        if ({r_co, r_sum} !== 9'h10F) begin
            n_fail++;
            $display("FAIL sub_10_01: got %h, expected 10f", {r_co, r_sum});
        end
        @(negedge clk);
        run_op(8'h01, 8'h02, 1, 0);
        n_tests++;
        if ({r_co, r_sum} !== 9'h0FF) begin
            n_fail++;
            $display("FAIL sub_01_02: got %h, expected 0ff", {r_co, r_sum});
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        test_reset;
        test_basic;
        test_back_to_back;
        test_start_during_run;
        test_reset_mid_run;
`ifdef SERIAL_ADDER_SUB_EN
        test_sub;
`endif
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire
